// File: rtl/barrel_coord_gen.sv
// -----------------------------------------------------------------------------
// barrel_coord_gen
//
// Request-side initiator for the barrel-projection line buffer. Raster-scans
// the output frame, maps every output pixel (ox,oy) to a source coordinate
// using a per-column signed vertical-offset LUT, and presents the result with
// valid/ready flow control plus SOF/EOL sideband for the AXIS stage.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high
//   enable      high: frames back-to-back; low: stop at the next frame end
//   lut_we      LUT write strobe
//   lut_addr    LUT column index (addresses >= WIDTH are ignored)
//   lut_dy      signed vertical offset written to column lut_addr
//   Math_Ready  line buffer can serve requests
//   Out_tReady  downstream pipeline enable; a request is consumed on a clock
//               edge where Math_Valid && Out_tReady
//   Math_X      source column (equals ox)
//   Math_Y      source row, oy + dy[ox] clamped to 0..HEIGHT-1
//   Math_Valid  request valid (RUN state and Math_Ready)
//   Out_SOF     request is output pixel (0,0)
//   Out_EOL     request is the last column of a line
//   busy        FSM not idle
// -----------------------------------------------------------------------------
module barrel_coord_gen #(
   parameter int unsigned WIDTH   = 1080,
   parameter int unsigned HEIGHT  = 960,
   parameter int unsigned DY_BITS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               lut_we,
   input  logic [10:0]        lut_addr,
   input  logic [DY_BITS-1:0] lut_dy,
   input  logic               Math_Ready,
   input  logic               Out_tReady,
   output logic [11:0]        Math_X,
   output logic [11:0]        Math_Y,
   output logic               Math_Valid,
   output logic               Out_SOF,
   output logic               Out_EOL,
   output logic               busy
);

   localparam int unsigned AW     = $clog2(WIDTH);
   localparam logic [11:0] W_LAST = 12'(WIDTH - 1);
   localparam logic [11:0] H_LAST = 12'(HEIGHT - 1);
   localparam logic [AW-1:0] ONE_A = AW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [11:0]        oy;
   logic               accept;
   logic               last_col;
   logic               last_pix;
   logic [11:0]        nx;
   logic [11:0]        ny;
   logic [AW-1:0]      after_nx;
   logic [AW-1:0]      rd_addr;
   logic               load;
   logic [11:0]        tx;
   logic [11:0]        ty;
   logic signed [13:0] sy;
   logic [11:0]        y_clamp;

   logic [DY_BITS-1:0] lut_mem [WIDTH];
   logic [DY_BITS-1:0] lut_q;

   assign Math_Valid = (state == S_RUN) && Math_Ready;
   assign accept     = Math_Valid && Out_tReady;
   assign busy       = (state != S_IDLE);
   assign last_col   = (Math_X == W_LAST);
   assign last_pix   = last_col && (oy == H_LAST);
   assign Out_SOF    = Math_Valid && (Math_X == '0) && (oy == '0);
   assign Out_EOL    = Math_Valid && last_col;

   // Raster successor of the position currently on the outputs.
   always_comb begin
      nx = Math_X + 12'd1;
      ny = oy;
      if (last_col) begin
         nx = '0;
         ny = last_pix ? '0 : oy + 12'd1;
      end
   end

   assign after_nx = (nx == W_LAST) ? '0 : nx[AW-1:0] + ONE_A;

   // lut_q must always hold dy of the column that the next load will use:
   // while stalled keep re-reading the successor column, on accept move one
   // column further, and at frame end / in IDLE point back at column 0 so
   // PRIME finds dy[0] ready.
   always_comb begin
      rd_addr = '0;
      case (state)
         S_PRIME: rd_addr = ONE_A;
         S_RUN: begin
            if (accept)
               rd_addr = last_pix ? '0 : after_nx;
            else
               rd_addr = nx[AW-1:0];
         end
         default: rd_addr = '0;
      endcase
   end

   always_comb begin
      load = 1'b0;
      tx   = nx;
      ty   = ny;
      if (state == S_PRIME) begin
         load = 1'b1;
         tx   = '0;
         ty   = '0;
      end else if (accept) begin
         load = 1'b1;
      end
   end

   always_comb begin
      sy = $signed({2'b00, ty}) +
           $signed({{(14 - DY_BITS){lut_q[DY_BITS-1]}}, lut_q});
      if (sy[13])
         y_clamp = '0;
      else if (sy > $signed({2'b00, H_LAST}))
         y_clamp = H_LAST;
      else
         y_clamp = sy[11:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (enable) state_nxt = S_PRIME;
         S_PRIME: state_nxt = S_RUN;
         S_RUN: begin
            if (accept && last_pix)
               state_nxt = enable ? S_PRIME : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         Math_X <= '0;
         Math_Y <= '0;
         oy     <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            Math_X <= tx;
            oy     <= ty;
            Math_Y <= y_clamp;
         end
      end
   end

   // LUT contents survive reset; a same-address write/read returns old data.
   always_ff @(posedge clk) begin
      if (lut_we && (32'(lut_addr) < WIDTH))
         lut_mem[lut_addr[AW-1:0]] <= lut_dy;
      lut_q <= lut_mem[rd_addr];
   end

endmodule

// File: tb/tb_barrel_coord_gen.sv
module tb_barrel_coord_gen;

   localparam int W = 20;
   localparam int H = 16;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        sof;
      logic        eol;
   } req_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        lut_we;
   logic [10:0] lut_addr;
   logic [7:0]  lut_dy;
   logic        Math_Ready;
   logic        Out_tReady;
   logic [11:0] Math_X;
   logic [11:0] Math_Y;
   logic        Math_Valid;
   logic        Out_SOF;
   logic        Out_EOL;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int accepts = 0;
   int sof_cnt = 0;
   int eol_cnt = 0;
   logic mon_en = 1'b0;

   logic signed [7:0] dy_m [W];
   req_t exp_q [$];

   barrel_coord_gen #(.WIDTH(W), .HEIGHT(H), .DY_BITS(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .lut_we(lut_we),
      .lut_addr(lut_addr), .lut_dy(lut_dy), .Math_Ready(Math_Ready),
      .Out_tReady(Out_tReady), .Math_X(Math_X), .Math_Y(Math_Y),
      .Math_Valid(Math_Valid), .Out_SOF(Out_SOF), .Out_EOL(Out_EOL),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [11:0] exp_y(input int y, input int x);
      int s;
      s = y + int'(dy_m[x]);
      if (s < 0) return 12'd0;
      if (s > H - 1) return 12'(H - 1);
      return 12'(s);
   endfunction

   task automatic push_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            exp_q.push_back('{x: 12'(x), y: exp_y(y, x), sof: (x == 0 && y == 0), eol: (x == W - 1)});
   endtask

   task automatic write_lut(input int addr, input logic [7:0] val);
      @(posedge clk); #1;
      lut_we = 1'b1; lut_addr = 11'(addr); lut_dy = val;
      @(posedge clk); #1;
      lut_we = 1'b0;
      if (addr < W) dy_m[addr] = val;
   endtask

   task automatic pulse_enable();
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk); #1 enable = 1'b0;
   endtask

   task automatic clear_counts();
      accepts = 0; sof_cnt = 0; eol_cnt = 0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_drained"}, exp_q.size(), 32'd0);
   endtask

   // Wait (sampled just after a clock edge) until the outputs show (x,y).
   task automatic wait_pos(input string tag, input int x, input int y, input int budget);
      int n;
      logic found;
      found = 1'b0;
      n = 0;
      while (!found && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (Math_Valid && Math_X == 12'(x) && Math_Y == 12'(y)) found = 1'b1;
      end
      check({tag, "_reached"}, {31'd0, found}, 32'd1);
   endtask

   // Scoreboard: every accepted request must match the next queued expectation.
   always @(negedge clk) begin
      if (mon_en && !reset && Math_Valid && Out_tReady) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_req: observed (%0d,%0d) expected none", Math_X, Math_Y);
         end else begin
            req_t e;
            e = exp_q.pop_front();
            checks++;
            assert ({Math_X, Math_Y, Out_SOF, Out_EOL} === e) else begin
               errors++;
               $error("FAIL req: observed x=%0d y=%0d sof=%0b eol=%0b expected x=%0d y=%0d sof=%0b eol=%0b",
                      Math_X, Math_Y, Out_SOF, Out_EOL, e.x, e.y, e.sof, e.eol);
            end
         end
         accepts++;
         if (Out_SOF) sof_cnt++;
         if (Out_EOL) eol_cnt++;
      end
   end

   initial begin
      int vcount;
      reset = 1'b1; enable = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_dy = '0;
      Math_Ready = 1'b1; Out_tReady = 1'b1;
      for (int i = 0; i < W; i++) write_lut(i, 8'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rst_x", 32'(Math_X), 32'd0);
      check("rst_y", 32'(Math_Y), 32'd0);
      check("rst_ctl", {28'd0, Math_Valid, Out_SOF, Out_EOL, busy}, 32'd0);
      mon_en = 1'b1;

      // 1: flat LUT, full frame, latency and counts
      clear_counts();
      push_frame();
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk); #1 enable = 1'b0;
      @(negedge clk);
      check("lat_prime_valid", {31'd0, Math_Valid}, 32'd0);
      check("lat_prime_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("lat_run_valid", {31'd0, Math_Valid}, 32'd1);
      wait_idle("t1", W * H + 20);
      check("t1_accepts", accepts, W * H);
      check("t1_sof", sof_cnt, 1);
      check("t1_eol", eol_cnt, H);

      // 2: clamping; the out-of-range write must not alias onto column 4
      write_lut(5, 8'hFD);
      write_lut(6, 8'd127);
      write_lut(7, 8'd2);
      write_lut(36, 8'd50);
      push_frame();
      pulse_enable();
      wait_idle("t2", W * H + 20);

      // 3: downstream stall on the last column of row 2
      push_frame();
      pulse_enable();
      wait_pos("t3", W - 1, 2, W * H);
      Out_tReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_hold_x", 32'(Math_X), W - 1);
         check("t3_hold_y", 32'(Math_Y), 32'd2);
         check("t3_hold_eol", {31'd0, Out_EOL}, 32'd1);
         @(posedge clk); #1;
      end
      Out_tReady = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_next_x", 32'(Math_X), 32'd0);
      check("t3_next_y", 32'(Math_Y), 32'd3);
      wait_idle("t3", W * H + 20);

      // 4: Math_Ready held low at start, later a short drop mid-frame
      Math_Ready = 1'b0;
      push_frame();
      pulse_enable();
      vcount = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (Math_Valid) vcount++;
      end
      check("t4_no_valid", vcount, 32'd0);
      check("t4_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1 Math_Ready = 1'b1;
      @(negedge clk);
      check("t4_first_valid", {31'd0, Math_Valid}, 32'd1);
      check("t4_first_sof", {31'd0, Out_SOF}, 32'd1);
      check("t4_first_xy", {8'd0, Math_X, Math_Y}, 32'd0);
      repeat (50) @(posedge clk);
      #1 Math_Ready = 1'b0;
      @(negedge clk);
      check("t4_drop_valid", {31'd0, Math_Valid}, 32'd0);
      repeat (3) @(posedge clk);
      #1 Math_Ready = 1'b1;
      wait_idle("t4", W * H + 20);

      // 5: back-to-back frames, enable dropped during frame 2
      clear_counts();
      push_frame();
      push_frame();
      @(posedge clk); #1 enable = 1'b1;
      wait_pos("t5_f1end", W - 1, H - 1, W * H + 20);
      @(negedge clk);
      @(negedge clk);
      check("t5_prime_valid", {31'd0, Math_Valid}, 32'd0);
      check("t5_prime_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("t5_f2_sof", {31'd0, Out_SOF}, 32'd1);
      repeat (30) @(posedge clk);
      #1 enable = 1'b0;
      wait_idle("t5", W * H + 20);
      check("t5_accepts", accepts, 2 * W * H);
      check("t5_sof", sof_cnt, 2);
      check("t5_eol", eol_cnt, 2 * H);

      // 6: reset mid-frame, then restart from (0,0)
      push_frame();
      pulse_enable();
      wait_pos("t6", W / 2, H / 2, W * H);
      mon_en = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("t6_rst_xy", {8'd0, Math_X, Math_Y}, 32'd0);
      check("t6_rst_ctl", {28'd0, Math_Valid, Out_SOF, Out_EOL, busy}, 32'd0);
      exp_q.delete();
      clear_counts();
      mon_en = 1'b1;
      push_frame();
      pulse_enable();
      wait_idle("t6", W * H + 20);
      check("t6_accepts", accepts, W * H);
      check("t6_sof", sof_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
